serial_mag_comparator: RTL
==========================

// Module: serial_mag_comparator
// PURPOSE
//  Bit-serial magnitude comparator: latches two WIDTH-bit unsigned operands on a
//  start pulse, compares them MSB-first one bit per clock, stops at the first
//  differing bit and reports G/L/E with a one-cycle done strobe. Sits in the
//  datapath library beside the combinational comparators, for area-limited sorting
//  and threshold units.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=1)
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  busy   out  1      high in SHIFT and DONE
//  done   out  1      one-cycle strobe: result valid
//  G      out  1      A > B
//  L      out  1      A < B
//  E      out  1      A == B
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=done=G=L=E=0; operand regs and
//    bit index cleared. Reset mid-compare aborts it, no done is produced.
//  - States: IDLE, SHIFT, DONE. All outputs registered.
//  - IDLE: start=1 at edge T0 -> capture a,b; idx=WIDTH-1; clear G/L/E; go SHIFT.
//  - SHIFT, each cycle, at bit idx of captured regs:
//    ra[idx]&~rb[idx] -> G=1, go DONE;  ~ra[idx]&rb[idx] -> L=1, go DONE;
//    bits equal and idx==0 -> E=1, go DONE;  bits equal, idx>0 -> idx=idx-1.
//  - DONE: done=1 for exactly this one cycle; next edge -> IDLE.
//  - Latency: m = bits examined (1..WIDTH), m = WIDTH - (index of first differing
//    bit), m = WIDTH when equal. Enters DONE at edge T0+m; done high during cycle
//    after T0+m; back to IDLE at T0+m+1. Next start accepted at edge T0+m+1 or later.
//  - G/L/E: exactly one high from DONE until the next accepted start (cleared at
//    that edge) or reset; all zero before the first result.
//  - start while busy (SHIFT or DONE) is ignored; a/b changes after capture have
//    no effect on the running compare.
//  - WIDTH=1: single SHIFT cycle; G=A&~B, L=~A&B, E=A~^B.
//  - idx width $clog2(WIDTH) (min 1); idx never decrements below 0.
// TESTING
//  1. WIDTH=8, a=8'hA5, b=8'h25, start 1 cycle -> MSB differs, m=1: done 1 cycle
//     after start edge+1, G=1 L=0 E=0, busy low 2 cycles after start edge.
//  2. a=8'h3C, b=8'h3C -> m=8: done one cycle after edge T0+8, E=1, G=L=0.
//  3. a=8'h10, b=8'h11 -> differs at LSB, m=8: L=1; then a=8'hFF,b=8'h00 -> G=1,
//     L cleared at second start edge.
//  4. start held high across a whole compare with a/b changing every cycle -> one
//     result for the values at T0 only; second compare begins at first IDLE edge.
//  5. rst asserted asynchronously 3 cycles into an 8-bit equal compare -> all
//     outputs 0 immediately, no done; fresh start afterwards completes normally.
//  6. WIDTH=1 instance, all four (a,b) combos -> G/L/E = 01->L, 10->G, 00/11->E,
//     done one cycle after start edge+1.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first unsigned comparator: G/L/E after m = WIDTH - (first differing bit index) SHIFT cycles, then a one-cycle done.
// No backpressure: start is taken only in IDLE and ignored while busy; results hold until the next accepted start.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             g_q, g_d, l_q, l_d, e_q, e_d;
    logic             bit_a, bit_b;

    // Operands shift left as bits match, so the bit under test is always the MSB.
    assign bit_a = ra_q[WIDTH-1];
    assign bit_b = rb_q[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = IW'(WIDTH - 1);
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bit_a & ~bit_b) begin
                    g_d     = 1'b1;
                    state_d = S_DONE;
                end else if (~bit_a & bit_b) begin
                    l_d     = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    e_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                    ra_d  = ra_q << 1;
                    rb_d  = rb_q << 1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        G    = g_q;
        L    = l_q;
        E    = e_q;
    end

endmodule
